// File: rtl/fp_pkg.sv
// fp_pkg: shared operand classes, flag bit positions and format constants for the FP multiplier
package fp_pkg;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;
  localparam int FLAG_INV = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UDF = 0;
  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fpm_round_pack.sv
// fpm_round_pack: final stage -- rounding (RNE when FPM_ROUND_RNE_EN is defined, else truncation), range check and packing
module fpm_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      sign,
  input  fp_class_e                 cls,
  input  logic signed [EXP_W+1:0]   exp,
  input  logic [MAN_W-1:0]          man,
`ifdef FPM_ROUND_RNE_EN
  input  logic                      guard,
  input  logic                      sticky,
`endif
  output logic [EXP_W+MAN_W:0]      result,
  output logic [2:0]                flags
);
  localparam logic signed [EXP_W+1:0] EMAX = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic [EXP_W+MAN_W:0] QNAN = (EXP_W+MAN_W+1)'(qnan(EXP_W, MAN_W));
  logic carry;
  logic [MAN_W-1:0] man_r;
  logic signed [EXP_W+1:0] exp_r;
`ifdef FPM_ROUND_RNE_EN
  // round up when above half, or exactly half with an odd lsb
  always_comb {carry, man_r} = {1'b0, man} + (MAN_W+1)'(guard & (sticky | man[0]));
`else
  // truncation never carries
  always_comb {carry, man_r} = {1'b0, man};
`endif
  assign exp_r = exp + $signed({{(EXP_W+1){1'b0}}, carry});
  // special classes first, then exponent range of the rounded normal result
  always_comb begin
    result = {sign, exp_r[EXP_W-1:0], man_r};
    flags  = '0;
    if (cls == CLS_NAN) begin
      result = QNAN;
      flags[FLAG_INV] = 1'b1;
    end else if (cls == CLS_INF) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls == CLS_ZERO) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_r >= EMAX) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags[FLAG_OVF] = 1'b1;
    end else if (exp_r <= 0) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
      flags[FLAG_UDF] = 1'b1;
    end
  end
endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage pipelined FP multiplier with global stall; FPM_ROUND_RNE_EN selects round-to-nearest-even over truncation
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [2:0]           flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'(bias(EXP_W));
`ifdef FPM_ROUND_RNE_EN
  localparam int PW = 2*MAN_W + 2;
`else
  localparam int PW = MAN_W + 2;
`endif
  logic advance, shift;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb, m_n, m2;
  logic [2*MAN_W+1:0] ma_x, mb_x;
  logic [PW-1:0] prod, p1;
  fp_class_e ca, cb, c_n, c1, c2;
  logic v1, v2, sg1, sg2;
  logic signed [EXP_W+1:0] e1, e2;
  logic [W-1:0] res_n;
  logic [2:0] flg_n;
`ifdef FPM_ROUND_RNE_EN
  logic g_n, st_n, g2, st2;
`endif
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign {ea, ma} = a[W-2:0];
  assign {eb, mb} = b[W-2:0];
  assign ma_x = {{(MAN_W+1){1'b0}}, 1'b1, ma};
  assign mb_x = {{(MAN_W+1){1'b0}}, 1'b1, mb};
`ifdef FPM_ROUND_RNE_EN
  assign prod = ma_x * mb_x;
`else
  assign prod = PW'((ma_x * mb_x) >> MAN_W);
`endif
  assign ca = ea == '0 ? CLS_ZERO : ea != '1 ? CLS_NORM : ma != '0 ? CLS_NAN : CLS_INF;
  assign cb = eb == '0 ? CLS_ZERO : eb != '1 ? CLS_NORM : mb != '0 ? CLS_NAN : CLS_INF;
  assign c_n = (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_INF && cb == CLS_ZERO) ||
                (ca == CLS_ZERO && cb == CLS_INF)) ? CLS_NAN :
               (ca == CLS_INF || cb == CLS_INF) ? CLS_INF :
               (ca == CLS_ZERO || cb == CLS_ZERO) ? CLS_ZERO : CLS_NORM;
  // S1: classify, multiply significands, sum exponents
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1  <= 1'b0;
      sg1 <= 1'b0;
      c1  <= CLS_ZERO;
      e1  <= '0;
      p1  <= '0;
    end else if (advance) begin
      v1  <= in_valid;
      sg1 <= a[W-1] ^ b[W-1];
      c1  <= c_n;
      e1  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
      p1  <= prod;
    end
  assign shift = p1[PW-1];
`ifdef FPM_ROUND_RNE_EN
  assign m_n  = shift ? p1[2*MAN_W:MAN_W+1] : p1[2*MAN_W-1:MAN_W];
  assign g_n  = shift ? p1[MAN_W] : p1[MAN_W-1];
  assign st_n = shift ? |p1[MAN_W-1:0] : |p1[MAN_W-2:0];
`else
  assign m_n = shift ? p1[MAN_W:1] : p1[MAN_W-1:0];
`endif
  // S2: normalise a product in [2,4) by one bit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2  <= 1'b0;
      sg2 <= 1'b0;
      c2  <= CLS_ZERO;
      e2  <= '0;
      m2  <= '0;
`ifdef FPM_ROUND_RNE_EN
      g2  <= 1'b0;
      st2 <= 1'b0;
`endif
    end else if (advance) begin
      v2  <= v1;
      sg2 <= sg1;
      c2  <= c1;
      e2  <= e1 + $signed({{(EXP_W+1){1'b0}}, shift});
      m2  <= m_n;
`ifdef FPM_ROUND_RNE_EN
      g2  <= g_n;
      st2 <= st_n;
`endif
    end
  fpm_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (sg2),
    .cls    (c2),
    .exp    (e2),
    .man    (m2),
`ifdef FPM_ROUND_RNE_EN
    .guard  (g2),
    .sticky (st2),
`endif
    .result (res_n),
    .flags  (flg_n)
  );
  // S3: output register, frozen while downstream stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      out_valid <= v2;
      result    <= res_n;
      flags     <= flg_n;
    end
endmodule

// File: doc/fp_mult_pipe.md
FP_MULT_PIPE -- requirements
Module: fp_mult_pipe

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 Parameter MAN_W, default 23, stored mantissa field width (range 4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  W each  IEEE-style operands {sign, exp, man}.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 result  output  W  product.
REQ-011 flags  output  3  {invalid, overflow, underflow} for the presented result.

Function
REQ-012 The block SHALL be a 3-stage pipeline: S1 unpack, special-case classify, (MAN_W+1)x(MAN_W+1) mantissa multiply, exponent sum; S2 normalise (1-bit shift if product >= 2), form guard/sticky; S3 round, exponent bias correction, overflow/underflow check, pack.
REQ-013 Latency SHALL be exactly 3 cycles from handshake (in_valid && in_ready) to out_valid with no stall; throughput one result per cycle.
REQ-014 Global stall: advance = !out_valid || out_ready; in_ready SHALL equal advance; when advance is low every stage holds its contents unchanged.
REQ-015 Each stage carries a valid bit; bubbles SHALL propagate without producing out_valid.
REQ-016 result and flags SHALL stay stable while out_valid && !out_ready.
REQ-017 Sign = a.sign XOR b.sign for all cases including zero and infinity.
REQ-018 Biased exponent = ea + eb - BIAS + norm_shift + round_carry, BIAS = 2^(EXP_W-1)-1, computed in EXP_W+2 signed bits.
REQ-019 Exponent field 0 inputs (zero/subnormal) SHALL be treated as signed zero (flush-to-zero).
REQ-020 NaN input, or infinity x zero, SHALL give canonical quiet NaN (exp all ones, man MSB set, sign 0), invalid=1.
REQ-021 Infinity x finite nonzero SHALL give signed infinity, no flags.
REQ-022 Biased exponent >= 2^EXP_W-1 after rounding SHALL give signed infinity, overflow=1.
REQ-023 Biased exponent <= 0 SHALL give signed zero, underflow=1 (no subnormal output).
REQ-024 Rounding carry out of mantissa SHALL increment exponent and re-check overflow.

Reset
REQ-025 rst asserted SHALL asynchronously clear all stage valid bits, out_valid=0, result=0, flags=0; in-flight operations are discarded.
REQ-026 in_ready SHALL be 1 during and after reset (pipeline empty).

Configuration
REQ-027 Macro FPM_ROUND_RNE_EN defined: round-to-nearest-ties-to-even using guard and sticky; undefined: truncation (round toward zero), guard/sticky logic removed.

Structure
REQ-028 Shared package fp_pkg SHALL hold the class enumeration (zero, normal, inf, nan), flag bit indices, and the BIAS/qNaN constant functions of EXP_W/MAN_W.
REQ-029 One sub-module fpm_round_pack SHALL implement S3 (rounding, overflow/underflow, packing).

Verification
REQ-030 a=0x3FC00000 (1.5), b=0x40000000 (2.0) -> result 0x40400000 after 3 cycles, flags 0.
REQ-031 a=0xC0400000 (-3.0), b=0x3F000000 (0.5) -> 0xBFC00000; a=0x7F800000, b=0x00000000 -> 0x7FC00000, invalid=1.
REQ-032 a=b=0x7F000000 -> 0x7F800000, overflow=1; a=b=0x00800000 -> 0x00000000, underflow=1.
REQ-033 a=0x3F800001, b=0x3FC00000 -> 0x3FC00002 with FPM_ROUND_RNE_EN, 0x3FC00001 without.
REQ-034 Four back-to-back inputs, out_ready low cycles 3-6 -> in_ready drops, four results emerge in order with none lost or duplicated; rst pulse mid-stream -> out_valid 0 immediately, no stale result afterwards.
